fifo_txuart: RTL and testbench
==============================

FIFO_TXUART -- requirements
Module: fifo_txuart

Interface
REQ-001 The module SHALL have parameter CLOCKS_PER_BAUD, default 24, giving clock cycles per UART bit period; legal range 1 to 2^24-1.
REQ-002 The module SHALL have a one-clock design; reset is synchronous and active-high.
REQ-003 Port i_clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port i_reset  input  1  synchronous active-high reset.
REQ-005 Port i_fifo_empty  input  1  upstream synchronous-FIFO empty flag; high means no data is available.
REQ-006 Port i_fifo_data  input  8  upstream FIFO head byte; valid whenever i_fifo_empty is low.
REQ-007 Port o_fifo_rd  output  1  pop strobe to the upstream FIFO read port; the head byte is consumed on a clock edge where it is high.
REQ-008 Port o_uart_tx  output  1  serial line, 8N1 format, idle high, registered.
REQ-009 Port o_busy  output  1  high while a frame is in progress.

Function
REQ-010 The block SHALL implement states IDLE, START, DATA, STOP, with o_busy = (state != IDLE).
REQ-011 o_fifo_rd SHALL be combinational: !i_reset && !i_fifo_empty && (state==IDLE || (state==STOP && baud_cnt==0)).
REQ-012 o_fifo_rd SHALL never be high while i_fifo_empty is high.
REQ-013 When o_fifo_rd is high, the block SHALL latch i_fifo_data into an 8-bit shift register, enter START, load baud_cnt = CLOCKS_PER_BAUD-1, and drive o_uart_tx=0 from the next cycle.
REQ-014 baud_cnt SHALL be at least 24 bits wide and decrement by 1 each cycle while not IDLE; the state advances only when baud_cnt==0, and baud_cnt reloads with CLOCKS_PER_BAUD-1 on each advance.
REQ-015 Every bit, including start and stop, SHALL drive o_uart_tx for exactly CLOCKS_PER_BAUD cycles.
REQ-016 Transition START->DATA: bit index = 0 and o_uart_tx = shift[0]; data SHALL be sent LSB first.
REQ-017 In DATA, at each baud_cnt==0 the shift register SHALL shift right by one and the bit index SHALL increment; after bit 7, DATA->STOP with o_uart_tx=1.
REQ-018 STOP at baud_cnt==0 SHALL transition to START if o_fifo_rd is high (back-to-back frames, zero idle gap), otherwise to IDLE.
REQ-019 A frame SHALL occupy exactly 10*CLOCKS_PER_BAUD cycles from the first start-bit cycle to the last stop-bit cycle.
REQ-020 With CLOCKS_PER_BAUD=1, every bit SHALL last one cycle and back-to-back frames SHALL still have no gap.
REQ-021 A change of i_fifo_data during a frame SHALL NOT affect the byte being sent.
REQ-022 At most one pop SHALL occur per frame.

Reset
REQ-023 When i_reset is high at a clock edge, the block SHALL on that edge set state=IDLE, o_uart_tx=1, o_busy=0, baud_cnt=0, bit index=0, and shift register=0.
REQ-024 o_fifo_rd SHALL be low during any cycle where i_reset is high.
REQ-025 A frame interrupted by reset SHALL be abandoned, with no completion and no retransmission; a byte popped before reset is lost.
REQ-026 Initial (power-up) values SHALL equal reset values.
REQ-027 The first pop after reset deasserts SHALL occur no earlier than the first cycle with i_reset low.

Verification
REQ-028 CPB=4, FIFO holds 0xA5 -> o_fifo_rd high 1 cycle; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; o_busy high 40 cycles; then IDLE with tx=1.
REQ-029 CPB=4, FIFO holds 0x00 and 0xFF -> second pop on the last stop cycle of frame 1; 80 contiguous busy cycles; tx = 0 for 36 cycles (start + 0x00 data), 1 for 4, 0 for 4, then 1 for 36.
REQ-030 CPB=4, i_fifo_empty held high for 100 cycles -> o_fifo_rd=0, o_uart_tx=1, o_busy=0 throughout.
REQ-031 CPB=4, reset asserted during data bit 3 of 0x3C -> next cycle tx=1, busy=0; no pop while reset is high; a fresh frame of the next FIFO byte starts after release.
REQ-032 CPB=1, bytes 0x01 and 0x80 -> 20 contiguous bit cycles: 0,1,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0,1,1.
REQ-033 All scenarios -> o_fifo_rd never high with i_fifo_empty high, and each bit-hold count equals CPB exactly.

Source files
------------

// File: rtl/fifo_txuart.sv
// 8N1 UART transmitter that pulls bytes straight from a synchronous FIFO read port.
// Back-to-back frames pop the next byte on the last stop-bit cycle so no idle gap appears.
module fifo_txuart #(
    parameter int unsigned CLOCKS_PER_BAUD = 24
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_fifo_empty,
    input  logic [7:0] i_fifo_data,
    output logic       o_fifo_rd,
    output logic       o_uart_tx,
    output logic       o_busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [23:0] RELOAD = 24'(CLOCKS_PER_BAUD - 1);

    state_t      state_q = IDLE;
    state_t      state_d;
    logic [23:0] baud_q  = '0;
    logic [23:0] baud_d;
    logic [2:0]  bit_q   = '0;
    logic [2:0]  bit_d;
    logic [7:0]  shift_q = '0;
    logic [7:0]  shift_d;
    logic        tx_q    = 1'b1;
    logic        tx_d;
    logic        fifo_rd;
    logic        baud_last;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        baud_last = (baud_q == '0);
        fifo_rd   = !i_reset && !i_fifo_empty &&
                    (state_q == IDLE || (state_q == STOP && baud_last));

        if (state_q != IDLE) begin
            baud_d = baud_last ? RELOAD : baud_q - 24'd1;
        end

        case (state_q)
            IDLE: begin
                if (fifo_rd) begin
                    state_d = START;
                    shift_d = i_fifo_data;
                    baud_d  = RELOAD;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                // Shift out LSB first; the stop bit follows the eighth data bit.
                if (baud_last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    if (fifo_rd) begin
                        state_d = START;
                        shift_d = i_fifo_data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        baud_d  = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign o_fifo_rd = fifo_rd;
    assign o_uart_tx = tx_q;
    assign o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_txuart.sv
// Bench for fifo_txuart: two instances (4 and 1 clocks per baud) fed from modelled FIFOs,
// line output compared cycle by cycle against frames expanded from each popped byte.
module tb_fifo_txuart;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rst_edge = 1'b1;
    logic [1:0]      fe = 2'b11;
    logic [1:0][7:0] fd = '0;
    logic [1:0]      rd;
    logic [1:0]      tx;
    logic [1:0]      busy;
    logic [1:0]      pend = '0;

    logic [7:0] fmem [2][$];
    bit         expq [2][$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_txuart #(.CLOCKS_PER_BAUD(4)) u_dut4 (
        .i_clk(clk), .i_reset(rst), .i_fifo_empty(fe[0]), .i_fifo_data(fd[0]),
        .o_fifo_rd(rd[0]), .o_uart_tx(tx[0]), .o_busy(busy[0]));

    fifo_txuart #(.CLOCKS_PER_BAUD(1)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_fifo_empty(fe[1]), .i_fifo_data(fd[1]),
        .o_fifo_rd(rd[1]), .o_uart_tx(tx[1]), .o_busy(busy[1]));

    function automatic int cpb(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic void chk(input bit ok, input string nm, input int k,
                                input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s (cpb=%0d) at %0t: got %0d, expected %0d",
                     nm, cpb(k), $time, act, exp);
        end
    endfunction

    // 8N1 frame: start 0, data LSB first, stop 1; each bit repeated cpb times.
    function automatic void push_frame(input int k, input logic [7:0] v);
        bit b;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      b = 1'b0;
            else if (i == 9) b = 1'b1;
            else             b = v[i-1];
            for (int r = 0; r < cpb(k); r++) expq[k].push_back(b);
        end
    endfunction

    always @(posedge clk) rst_edge <= rst;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int sz;
            bit exp_rd;
            bit eb;
            if (rst_edge) expq[k].delete();
            sz = expq[k].size();
            exp_rd = !rst && (fmem[k].size() != 0) && (sz <= 1);
            chk(rd[k] == exp_rd, "fifo_rd", k, rd[k], exp_rd);
            chk(!(rd[k] && fe[k]), "rd_while_empty", k, rd[k], 0);
            if (sz > 0) begin
                eb = expq[k].pop_front();
                chk(busy[k] == 1'b1, "busy", k, busy[k], 1);
                chk(tx[k] == eb, "uart_tx", k, tx[k], eb);
            end else begin
                chk(busy[k] == 1'b0, "idle_busy", k, busy[k], 0);
                chk(tx[k] == 1'b1, "idle_tx", k, tx[k], 1);
            end
            pend[k] = rd[k];
            if (rd[k] && fmem[k].size() != 0) push_frame(k, fmem[k][0]);
        end
    end

    task automatic drive();
        for (int k = 0; k < 2; k++) begin
            fe[k] = (fmem[k].size() == 0);
            fd[k] = fe[k] ? 8'($urandom) : fmem[k][0];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++)
            if (pend[k] && fmem[k].size() != 0) void'(fmem[k].pop_front());
        drive();
    endtask

    task automatic push(input int k, input logic [7:0] v);
        fmem[k].push_back(v);
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((fmem[0].size() != 0 || fmem[1].size() != 0 ||
                expq[0].size() != 0 || expq[1].size() != 0) && budget < 3000) begin
            step();
            budget++;
        end
        chk(budget < 3000, "drain_timeout", 0, budget, 0);
        run(3);
    endtask

    initial begin
        drive();
        #1;
        chk(tx == 2'b11, "powerup_tx", 0, tx, 3);
        chk(busy == 2'b00, "powerup_busy", 0, busy, 0);
        run(3);
        rst = 1'b0;

        // Single byte, then a back-to-back pair on each instance.
        push(0, 8'hA5);
        push(1, 8'h01);
        push(1, 8'h80);
        drain();
        push(0, 8'h00);
        push(0, 8'hFF);
        drain();

        // Long empty stretch.
        run(100);

        // Reset in the middle of a frame; the following byte must go out cleanly.
        push(0, 8'h3C);
        push(0, 8'h5A);
        push(1, 8'hC3);
        begin
            int n;
            n = 0;
            while (!pend[0] && n < 50) begin
                step();
                n++;
            end
            chk(n < 50, "wait_pop_timeout", 0, n, 0);
        end
        run(17);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        drain();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            step();
            rst = ($urandom_range(0, 600) == 0);
            if ($urandom_range(0, 30) == 0 && fmem[0].size() < 4) push(0, 8'($urandom));
            if ($urandom_range(0, 6) == 0 && fmem[1].size() < 4) push(1, 8'($urandom));
        end
        step();
        rst = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
